// File: rtl/cd_sector_buf_ctrl.sv
// cd_sector_buf_ctrl: ping-pong sector buffer controller between the SPI CD download and the decoder/DMA reader.
// Optional `CDBUF_DROP_CNT_EN adds a saturating drop_cnt output.
module cd_sector_buf_ctrl #(
  parameter int SECTOR_WORDS = 1024
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        flush,
  input  logic        wr_download,
  input  logic        wr_strobe,
  input  logic [10:0] wr_addr,
  input  logic [15:0] wr_din,
  output logic        wr_ready,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [15:0] ram_din,
  output logic        rd_avail,
  output logic        rd_bank,
  output logic [10:0] rd_len,
  input  logic        rd_start,
  input  logic        rd_done,
  output logic        overflow
`ifdef CDBUF_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);
  localparam logic [1:0] EMPTY = 2'd0, FILL = 2'd1, FULL = 2'd2, READ = 2'd3;
  localparam logic [10:0] LAST = 11'(SECTOR_WORDS - 1);
  logic [1:0][1:0] st, st_n;
  logic [1:0][10:0] last_addr, la_n;
  logic wr_bank, wb_n, rb_n, dl_q, wr_ok, drop, fall;
  assign wr_ready = st[wr_bank] == EMPTY || st[wr_bank] == FILL;
  assign wr_ok = wr_strobe && wr_download && wr_ready;
  assign drop = wr_strobe && wr_download && !wr_ready;
  assign fall = dl_q && !wr_download;
  assign rd_avail = st[rd_bank] == FULL;
  assign rd_len = last_addr[rd_bank];
  // Write is applied first; the download edge then sees the updated bank state.
  always_comb begin
    st_n = st;
    la_n = last_addr;
    wb_n = wr_bank;
    rb_n = rd_bank;
    if (wr_ok) begin
      la_n[wr_bank] = wr_addr;
      st_n[wr_bank] = wr_addr == LAST ? FULL : FILL;
      wb_n = wr_addr == LAST ? ~wr_bank : wr_bank;
    end
    if (fall && st_n[wb_n] == FILL) begin
      st_n[wb_n] = FULL;
      wb_n = ~wb_n;
    end
    if (rd_done && st[rd_bank] == READ) begin
      st_n[rd_bank] = EMPTY;
      rb_n = ~rd_bank;
    end else if (rd_start && st[rd_bank] == FULL)
      st_n[rd_bank] = READ;
  end
  always_ff @(posedge clk_sys or posedge reset)
    if (reset) dl_q <= 1'b0;
    else dl_q <= wr_download;
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset || flush) begin
      st        <= '0;
      last_addr <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      overflow  <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
    end else begin
      st        <= st_n;
      last_addr <= la_n;
      wr_bank   <= wb_n;
      rd_bank   <= rb_n;
      ram_we    <= wr_ok;
      if (wr_ok) begin
        ram_addr <= {wr_bank, wr_addr};
        ram_din  <= wr_din;
      end
      if (drop) overflow <= 1'b1;
    end
  end
`ifdef CDBUF_DROP_CNT_EN
  always_ff @(posedge clk_sys or posedge reset)
    if (reset || flush) drop_cnt <= '0;
    else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_cd_sector_buf_ctrl.sv
// tb_cd_sector_buf_ctrl: directed vector table plus multi-cycle sequences for cd_sector_buf_ctrl.
module tb_cd_sector_buf_ctrl;
  logic clk_sys = 1'b0, reset = 1'b1, flush = 1'b0, wr_download = 1'b0, wr_strobe = 1'b0;
  logic rd_start = 1'b0, rd_done = 1'b0;
  logic [10:0] wr_addr = '0;
  logic [15:0] wr_din = '0;
  logic wr_ready, ram_we, rd_avail, rd_bank, overflow;
  logic [11:0] ram_addr;
  logic [15:0] ram_din;
  logic [10:0] rd_len;
`ifdef CDBUF_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int pass_n = 0, total_n = 0;

  cd_sector_buf_ctrl #(.SECTOR_WORDS(1024)) dut (
    .clk_sys(clk_sys), .reset(reset), .flush(flush), .wr_download(wr_download),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_din(wr_din), .wr_ready(wr_ready),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .rd_avail(rd_avail),
    .rd_bank(rd_bank), .rd_len(rd_len), .rd_start(rd_start), .rd_done(rd_done),
    .overflow(overflow)
`ifdef CDBUF_DROP_CNT_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic fl, dl, st;
    logic [10:0] ad;
    logic rs, rd;
    logic we;
    logic [11:0] ra;
    logic rdy, av, rb;
    logic [10:0] len;
    logic ov;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic do_reset();
    {flush, wr_download, wr_strobe, rd_start, rd_done} = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic write_words(input logic bank, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      wr_download = 1'b1;
      wr_strobe = 1'b1;
      wr_addr = 11'(i);
      wr_din = 16'(i * 7 + 3) ^ {15'd0, bank};
      step();
      wr_strobe = 1'b0;
      chk("wr_we", {15'd0, ram_we}, 16'd1);
      chk("wr_addr", {4'd0, ram_addr}, {4'd0, bank, 11'(i)});
      chk("wr_din", ram_din, 16'(i * 7 + 3) ^ {15'd0, bank});
    end
  endtask

  initial begin
    //          fl  dl  st  addr     rs  rd  we  ra       rdy av  rb  len      ov
    tbl[0]  = '{1'b0,1'b0,1'b0,11'd0,   1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,1'b0,11'd0,   1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,11'd5,   1'b0,1'b0,1'b1,12'h005,1'b1,1'b0,1'b0,11'd5,   1'b0};
    tbl[2]  = '{1'b0,1'b0,1'b1,11'd7,   1'b0,1'b0,1'b0,12'h005,1'b1,1'b1,1'b0,11'd5,   1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,11'd0,   1'b1,1'b0,1'b0,12'h005,1'b1,1'b0,1'b0,11'd5,   1'b0};
    tbl[4]  = '{1'b0,1'b1,1'b1,11'd3,   1'b0,1'b0,1'b1,12'h803,1'b1,1'b0,1'b0,11'd5,   1'b0};
    tbl[5]  = '{1'b0,1'b1,1'b0,11'd0,   1'b1,1'b1,1'b0,12'h803,1'b1,1'b0,1'b1,11'd3,   1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,11'd1023,1'b0,1'b0,1'b1,12'hBFF,1'b1,1'b1,1'b1,11'd1023,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b0,11'd0,   1'b0,1'b1,1'b0,12'hBFF,1'b1,1'b1,1'b1,11'd1023,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b0,11'd0,   1'b1,1'b0,1'b0,12'hBFF,1'b1,1'b0,1'b1,11'd1023,1'b0};
    tbl[9]  = '{1'b1,1'b1,1'b1,11'd9,   1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,1'b0,11'd0,   1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,11'd0,   1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,1'b0,11'd0,   1'b0};
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 11; i++) begin
      flush = tbl[i].fl; wr_download = tbl[i].dl; wr_strobe = tbl[i].st; wr_addr = tbl[i].ad;
      wr_din = 16'hBEEF; rd_start = tbl[i].rs; rd_done = tbl[i].rd;
      step();
      chk($sformatf("v%0d_we", i), {15'd0, ram_we}, {15'd0, tbl[i].we});
      chk($sformatf("v%0d_addr", i), {4'd0, ram_addr}, {4'd0, tbl[i].ra});
      chk($sformatf("v%0d_rdy", i), {15'd0, wr_ready}, {15'd0, tbl[i].rdy});
      chk($sformatf("v%0d_avail", i), {15'd0, rd_avail}, {15'd0, tbl[i].av});
      chk($sformatf("v%0d_rbank", i), {15'd0, rd_bank}, {15'd0, tbl[i].rb});
      chk($sformatf("v%0d_len", i), {5'd0, rd_len}, {5'd0, tbl[i].len});
      chk($sformatf("v%0d_ovf", i), {15'd0, overflow}, {15'd0, tbl[i].ov});
    end

    // full sector, then ping-pong with overflow
    do_reset();
    write_words(1'b0, 0, 1023);
    wr_download = 1'b0;
    step();
    chk("full_we_pulse", {15'd0, ram_we}, 16'd0);
    chk("full_avail", {15'd0, rd_avail}, 16'd1);
    chk("full_rbank", {15'd0, rd_bank}, 16'd0);
    chk("full_len", {5'd0, rd_len}, 16'd1023);
    chk("full_rdy", {15'd0, wr_ready}, 16'd1);
    write_words(1'b1, 0, 1023);
    wr_download = 1'b0;
    step();
    chk("pp_rdy", {15'd0, wr_ready}, 16'd0);
    wr_download = 1'b1; wr_strobe = 1'b1; wr_addr = 11'd0;
    step();
    wr_strobe = 1'b0;
    chk("pp_drop_we", {15'd0, ram_we}, 16'd0);
    chk("pp_ovf", {15'd0, overflow}, 16'd1);
    wr_download = 1'b0;
    step();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("pp_rdy_back", {15'd0, wr_ready}, 16'd1);
    chk("pp_rbank", {15'd0, rd_bank}, 16'd1);
    chk("pp_avail", {15'd0, rd_avail}, 16'd1);
    write_words(1'b0, 0, 3);

    // sector completion and rd_done in the same cycle
    do_reset();
    write_words(1'b0, 0, 1023);
    wr_download = 1'b0;
    step();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    chk("sim_avail_read", {15'd0, rd_avail}, 16'd0);
    write_words(1'b1, 0, 1022);
    wr_strobe = 1'b1; wr_addr = 11'd1023; rd_done = 1'b1;
    step();
    {wr_strobe, rd_done} = '0;
    chk("sim_addr", {4'd0, ram_addr}, 16'h0BFF);
    chk("sim_rbank", {15'd0, rd_bank}, 16'd1);
    chk("sim_avail", {15'd0, rd_avail}, 16'd1);
    chk("sim_len", {5'd0, rd_len}, 16'd1023);
    chk("sim_rdy", {15'd0, wr_ready}, 16'd1);

    // short sector
    do_reset();
    write_words(1'b0, 0, 9);
    wr_download = 1'b0;
    step();
    chk("short_avail", {15'd0, rd_avail}, 16'd1);
    chk("short_len", {5'd0, rd_len}, 16'd9);
    write_words(1'b1, 0, 0);

    // flush with bank 0 in READ and bank 1 in FILL
    do_reset();
    write_words(1'b0, 0, 1023);
    wr_download = 1'b0;
    step();
    rd_start = 1'b1;
    step();
    rd_start = 1'b0;
    write_words(1'b1, 0, 500);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_avail", {15'd0, rd_avail}, 16'd0);
    chk("fl_rbank", {15'd0, rd_bank}, 16'd0);
    chk("fl_ovf", {15'd0, overflow}, 16'd0);
    chk("fl_len", {5'd0, rd_len}, 16'd0);
    chk("fl_addr", {4'd0, ram_addr}, 16'd0);
    rd_done = 1'b1;
    step();
    rd_done = 1'b0;
    chk("fl_done_rbank", {15'd0, rd_bank}, 16'd0);
    chk("fl_done_avail", {15'd0, rd_avail}, 16'd0);
    write_words(1'b0, 0, 0);

    // async reset between edges, mid-sector
    wr_download = 1'b0;
    step();
    write_words(1'b1, 0, 2);
    chk("ar_pre_avail", {15'd0, rd_avail}, 16'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_we", {15'd0, ram_we}, 16'd0);
    chk("ar_avail", {15'd0, rd_avail}, 16'd0);
    chk("ar_rdy", {15'd0, wr_ready}, 16'd1);
    chk("ar_addr", {4'd0, ram_addr}, 16'd0);
    wr_download = 1'b0;
    #2 reset = 1'b0;
    step();

`ifdef CDBUF_DROP_CNT_EN
    do_reset();
    write_words(1'b0, 0, 1023);
    write_words(1'b1, 0, 1023);
    wr_download = 1'b1; wr_strobe = 1'b1;
    for (int i = 0; i < 300; i++) step();
    wr_strobe = 1'b0;
    wr_download = 1'b0;
    step();
    chk("dc_sat", {8'd0, drop_cnt}, 16'd255);
    chk("dc_ovf", {15'd0, overflow}, 16'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("dc_flush", {8'd0, drop_cnt}, 16'd0);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
